// File: rtl/kamus_ex_mc.sv
// kamus_ex_mc: execute unit with single-cycle ALU ops and iterative
// radix-2 multiply / divide, behind a valid/ready handshake on both sides.
module kamus_ex_mc #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1,
    parameter int DIV_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3,
        OP_XOR = 5'd4,  OP_OR  = 5'd5,  OP_AND = 5'd6,  OP_SLL  = 5'd7,
        OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11,
        OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15,
        OP_REM = 5'd16, OP_REMU = 5'd17
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e            r_state, w_state_nxt;
    logic [4:0]        r_op;
    logic [XLEN-1:0]   r_a, r_hi, r_lo, r_opnd, r_result;
    logic              r_neg_q, r_neg_r, r_b_zero, r_illegal;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept, w_is_mul, w_is_div, w_iter, w_illegal;
    logic              w_a_sgn, w_b_sgn, w_last, w_r_is_mul;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_alu;
    logic [XLEN:0]     w_msum, w_trial;
    logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt, w_quo, w_rem, w_iter_res;
    logic [2*XLEN-1:0] w_prod, w_prod_s;

    // Decode the offered op: class, enablement and operand magnitudes.
    always_comb begin
        w_is_mul  = (op_i >= OP_MUL) && (op_i <= OP_MULHU);
        w_is_div  = (op_i >= OP_DIV) && (op_i <= OP_REMU);
        w_iter    = (w_is_mul && (MUL_EN != 0)) || (w_is_div && (DIV_EN != 0));
        w_illegal = (op_i > OP_REMU) || (w_is_mul && (MUL_EN == 0)) ||
                    (w_is_div && (DIV_EN == 0));
        w_a_sgn   = ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                     (op_i == OP_DIV) || (op_i == OP_REM)) && a_i[XLEN-1];
        w_b_sgn   = ((op_i == OP_MULH) || (op_i == OP_DIV) ||
                     (op_i == OP_REM)) && b_i[XLEN-1];
        w_a_mag   = w_a_sgn ? -a_i : a_i;
        w_b_mag   = w_b_sgn ? -b_i : b_i;
    end

    // Single-cycle ALU result straight from the offered operands.
    always_comb begin
        // NOTE: default first so every path assigns w_alu and no latch is inferred.
        w_alu = '0;
        case (op_i)
            OP_ADD:  w_alu = a_i + b_i;
            OP_SUB:  w_alu = a_i - b_i;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            OP_XOR:  w_alu = a_i ^ b_i;
            OP_OR:   w_alu = a_i | b_i;
            OP_AND:  w_alu = a_i & b_i;
            OP_SLL:  w_alu = a_i << b_i[SH_W-1:0];
            OP_SRL:  w_alu = a_i >> b_i[SH_W-1:0];
            OP_SRA:  w_alu = $signed(a_i) >>> b_i[SH_W-1:0];
            default: w_alu = '0;
        endcase
    end

    // One radix-2 step: shift-add for multiply, restoring step for divide.
    // Multiply keeps {hi,lo} = partial product / remaining multiplier;
    // divide keeps hi = partial remainder, lo = dividend bits / quotient.
    always_comb begin
        w_r_is_mul = (r_op >= OP_MUL) && (r_op <= OP_MULHU);
        w_msum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_trial    = {r_hi, r_lo[XLEN-1]} - {1'b0, r_opnd};
        if (w_r_is_mul) begin
            w_hi_nxt = w_msum[XLEN:1];
            w_lo_nxt = {w_msum[0], r_lo[XLEN-1:1]};
        end else if (!w_trial[XLEN]) begin
            w_hi_nxt = w_trial[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
        end else begin
            w_hi_nxt = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
            w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
        end
        w_last = (r_cnt == CNT_W'(XLEN - 1));
    end

    // Sign-correct the final step's magnitudes and pick the requested half.
    always_comb begin
        w_prod   = {w_hi_nxt, w_lo_nxt};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_quo    = r_neg_q ? -w_lo_nxt : w_lo_nxt;
        w_rem    = r_neg_r ? -w_hi_nxt : w_hi_nxt;
        case (r_op)
            OP_MUL:                         w_iter_res = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   w_iter_res = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                w_iter_res = r_b_zero ? '1 : w_quo;
            default:                        w_iter_res = r_b_zero ? r_a : w_rem;
        endcase
    end

    // Next state and handshake outputs; flush forces IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        valid_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) w_state_nxt = w_iter ? S_CALC : S_DONE;
            end
            S_CALC: if (w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                valid_o = 1'b1;
                if (ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) w_state_nxt = S_IDLE;
    end

    assign w_accept  = valid_i && ready_o && !flush_i;
    assign result_o  = r_result;
    assign illegal_o = r_illegal;

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op      <= '0;
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_b_zero  <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_op     <= op_i;
            r_a      <= a_i;
            r_hi     <= '0;
            r_lo     <= w_is_mul ? w_b_mag : w_a_mag;
            r_opnd   <= w_is_mul ? w_a_mag : w_b_mag;
            r_neg_q  <= w_a_sgn ^ w_b_sgn;
            r_neg_r  <= w_a_sgn;
            r_b_zero <= (b_i == '0);
            r_cnt    <= '0;
            if (!w_iter) begin
                r_result  <= w_illegal ? '0 : w_alu;
                r_illegal <= w_illegal;
            end
        end else if ((r_state == S_CALC) && !flush_i) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result  <= w_iter_res;
                r_illegal <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_kamus_ex_mc.sv
// Self-checking bench for kamus_ex_mc: directed corner cases plus random
// ops compared against an arithmetic reference model.
module tb_kamus_ex_mc;
    logic        clk = 1'b0;
    logic        rst, valid_i, flush_i, ready_i;
    logic [4:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        ready_o, valid_o, illegal_o;
    logic [31:0] result_o;
    logic        nm_ready, nm_valid, nm_illegal;
    logic [31:0] nm_result;
    int          n_checks = 0;
    int          n_fail   = 0;

    kamus_ex_mc #(.XLEN(32), .MUL_EN(1), .DIV_EN(1)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .illegal_o(illegal_o)
    );

    kamus_ex_mc #(.XLEN(32), .MUL_EN(0), .DIV_EN(1)) dut_nomul (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(nm_ready),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .valid_o(nm_valid), .ready_i(ready_i), .result_o(nm_result),
        .illegal_o(nm_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {illegal, result} from the arithmetic definition of each op.
    function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        int          sa, sb;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd3:  r = (a < b) ? 32'd1 : 32'd0;
            5'd4:  r = a ^ b;
            5'd5:  r = a | b;
            5'd6:  r = a & b;
            5'd7:  r = a << b[4:0];
            5'd8:  r = a >> b[4:0];
            5'd9:  r = 32'(sa >>> b[4:0]);
            5'd10: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            5'd11: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            5'd12: begin p = longint'(sa) * longint'({32'd0, b}); r = p[63:32]; end
            5'd13: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            5'd14: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'(sa / sb);
            end
            5'd15: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd16: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'(sa % sb);
            end
            5'd17: r = (b == 0) ? a : a % b;
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, r};
    endfunction

    task automatic do_reset();
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        op_i = '0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one op, hold the result for 'stall' cycles, then hand it off.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [32:0] exp;
        logic [31:0] held;
        int          lat, exp_lat;
        exp     = model(op, a, b);
        exp_lat = (op >= 5'd10 && op <= 5'd17) ? 33 : 1;
        @(negedge clk);
        check({tag, ".ready_in"}, 64'(ready_o), 64'd1);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b; ready_i = (stall == 0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".result"}, 64'(result_o), 64'(exp[31:0]));
        check({tag, ".illegal"}, 64'(illegal_o), 64'(exp[32]));
        if (lat >= 100) begin
            do_reset();
            return;
        end
        held = result_o;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, ".stall_valid"}, 64'(valid_o), 64'd1);
            check({tag, ".stall_result"}, 64'(result_o), 64'(held));
            check({tag, ".stall_ready"}, 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check({tag, ".handoff"}, 64'(valid_o), 64'd0);
    endtask

    // Watch for any valid_o over n cycles; returns 1 if one appeared.
    task automatic watch_valid(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (valid_o) seen = 1'b1;
        end
    endtask

    initial begin
        logic        seen;
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] corners [5];
        corners[0] = 32'd0;          corners[1] = 32'd1;
        corners[2] = 32'hFFFF_FFFF;  corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;

        do_reset();
        #1;
        check("rst.ready", 64'(ready_o), 64'd1);
        check("rst.valid", 64'(valid_o), 64'd0);
        check("rst.result", 64'(result_o), 64'd0);
        check("rst.illegal", 64'(illegal_o), 64'd0);

        run_op("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("mulh_min", 5'd11, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhu_max", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_neg", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu_z", 5'd15, 32'd7, 32'd0, 0);
        run_op("remu_z", 5'd17, 32'd7, 32'd0, 0);
        run_op("div_z_neg", 5'd14, 32'hFFFF_FFF9, 32'd0, 0);
        run_op("rem_z_neg", 5'd16, 32'hFFFF_FFF9, 32'd0, 0);
        run_op("div_neg", 5'd14, 32'hFFFF_FFF9, 32'd2, 5);
        run_op("rem_neg", 5'd16, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("sra", 5'd9, 32'h8000_00F0, 32'h0000_0024, 0);
        run_op("slt", 5'd2, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sltu", 5'd3, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("op25", 5'd25, 32'd3, 32'd4, 2);

        // Flush at CALC cycle 10 of a DIVU abandons it.
        @(negedge clk);
        valid_i = 1'b1; op_i = 5'd15; a_i = 32'd1000; b_i = 32'd7; ready_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush.ready", 64'(ready_o), 64'd1);
        check("flush.valid", 64'(valid_o), 64'd0);
        watch_valid(40, seen);
        check("flush.no_valid", 64'(seen), 64'd0);
        ready_i = 1'b0;
        run_op("post_flush_add", 5'd0, 32'd2, 32'd3, 0);

        // Flush with valid_i in IDLE: no accept.
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b1; op_i = 5'd0; a_i = 32'd1; b_i = 32'd1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        watch_valid(3, seen);
        check("flush_idle.no_accept", 64'(seen), 64'd0);
        check("flush_idle.ready", 64'(ready_o), 64'd1);

        // Reset mid-CALC abandons the multiply.
        @(negedge clk);
        valid_i = 1'b1; op_i = 5'd10; a_i = 32'd12345; b_i = 32'd678; ready_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_calc.ready", 64'(ready_o), 64'd1);
        check("rst_calc.valid", 64'(valid_o), 64'd0);
        check("rst_calc.result", 64'(result_o), 64'd0);
        watch_valid(40, seen);
        check("rst_calc.no_valid", 64'(seen), 64'd0);
        ready_i = 1'b0;

        // MUL_EN=0 build: MUL and op 25 are illegal single-cycle ops.
        do_reset();
        @(negedge clk);
        valid_i = 1'b1; op_i = 5'd10; a_i = 32'd6; b_i = 32'd7;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("nomul.mul_valid", 64'(nm_valid), 64'd1);
        check("nomul.mul_illegal", 64'(nm_illegal), 64'd1);
        check("nomul.mul_result", 64'(nm_result), 64'd0);
        check("mul_en.still_calc", 64'(valid_o), 64'd0);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check("nomul.handoff", 64'(nm_valid), 64'd0);
        @(negedge clk);
        valid_i = 1'b1; op_i = 5'd25;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("nomul.op25_valid", 64'(nm_valid), 64'd1);
        check("nomul.op25_illegal", 64'(nm_illegal), 64'd1);
        check("nomul.op25_result", 64'(nm_result), 64'd0);
        do_reset();

        // Random ops against the reference model.
        for (int k = 0; k < 60; k++) begin
            rop = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'($urandom_range(0, 17));
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40));
            run_op($sformatf("rnd%0d_op%0d", k, rop), rop, ra, rb, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
